// File: rtl/line_steer_pkg.sv
// Shared constants, state encoding and helpers for the line-follower steering controller.
package line_steer_pkg;

    localparam logic [3:0] PROCEED      = 4'b0000;
    localparam logic [3:0] STOP         = 4'b1111;
    localparam logic [3:0] VEER_LEFT    = 4'b0101;
    localparam logic [3:0] HARD_LEFT    = 4'b0110;
    localparam logic [3:0] NINETY_LEFT  = 4'b0111;
    localparam logic [3:0] VEER_RIGHT   = 4'b1001;
    localparam logic [3:0] HARD_RIGHT   = 4'b1010;
    localparam logic [3:0] NINETY_RIGHT = 4'b1011;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_BWD = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRACK    = 3'd1,
        DEBOUNCE = 3'd2,
        DECIDE   = 3'd3,
        SEARCH   = 3'd4
    } state_e;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/line_sense_sync.sv
// Multi-flop synchroniser for a vector of asynchronous pins; every bit sees the same depth.
module line_sense_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift pins through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/line_steer_ctrl.sv
// Line-follower steering controller: debounces the active sensor bar, grades the line offset
// into steering commands and resolves ninety-degree turns, intersections and line loss.
module line_steer_ctrl
    import line_steer_pkg::*;
#(
    parameter int N_SENS        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CYC  = 20_000,
    parameter int INTERSECT_CYC = 30_000_000,
    parameter int VEER_THRESH   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              direction,
    input  logic [N_SENS-1:0] sens_front_n,
    input  logic [N_SENS-1:0] sens_rear_n,
    input  logic [1:0]        sens_mid_n,
    output logic [3:0]        dir_cmd,
    output logic              cmd_strobe,
    output logic              intersect_evt,
    output logic              lost_line
);

    localparam int SYNC_W = 2 * N_SENS + 3;
    localparam int SNAP_W = N_SENS + 3;
    localparam int HALF   = N_SENS / 2;
    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SRCH_W = (INTERSECT_CYC > 1) ? $clog2(INTERSECT_CYC) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(INTERSECT_CYC - 1);

    logic [SYNC_W-1:0] sync_s;
    logic              dir_s;
    logic [N_SENS-1:0] front_s;
    logic [N_SENS-1:0] rear_s;
    logic [N_SENS-1:0] bar_s;
    logic [N_SENS-1:0] dec_bar_s;
    logic [1:0]        mid_s;
    logic [SNAP_W-1:0] snap_s;
    logic [5:0]        left_s;
    logic [5:0]        right_s;
    logic [3:0]        grade_s;

    state_e            state_q;
    logic [SNAP_W-1:0] snap_q;
    logic [SNAP_W-1:0] decided_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [SRCH_W-1:0] srch_cnt_q;
    logic              ninety_q;

    line_sense_sync #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({direction, sens_front_n, sens_rear_n, sens_mid_n}),
        .q_o   (sync_s)
    );

    // Sensors are active-low on the pins; from here on 1 means line seen.
    assign dir_s     = sync_s[SYNC_W-1];
    assign front_s   = ~sync_s[SYNC_W-2 -: N_SENS];
    assign rear_s    = ~sync_s[N_SENS+1 -: N_SENS];
    assign mid_s     = ~sync_s[1:0];
    assign bar_s     = (dir_s == DIR_FWD) ? front_s : rear_s;
    assign snap_s    = {dir_s, bar_s, mid_s};
    assign dec_bar_s = snap_q[N_SENS+1:2];
    assign left_s    = popcount(32'(dec_bar_s[N_SENS-1:HALF]));
    assign right_s   = popcount(32'(dec_bar_s[HALF-1:0]));

    // Grade the debounced bar into a steering command.
    always_comb begin
        grade_s = PROCEED;
        if (left_s > right_s) begin
            if ((left_s - right_s) <= 6'(VEER_THRESH)) begin
                grade_s = VEER_LEFT;
            end else begin
                grade_s = HARD_LEFT;
            end
        end else if (right_s > left_s) begin
            if ((right_s - left_s) <= 6'(VEER_THRESH)) begin
                grade_s = VEER_RIGHT;
            end else begin
                grade_s = HARD_RIGHT;
            end
        end else begin
            grade_s = PROCEED;
        end
    end

    // Steering state machine with registered command and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dir_cmd       <= STOP;
            cmd_strobe    <= 1'b0;
            intersect_evt <= 1'b0;
            lost_line     <= 1'b0;
            deb_cnt_q     <= {DEB_W{1'b0}};
            srch_cnt_q    <= {SRCH_W{1'b0}};
            snap_q        <= {SNAP_W{1'b0}};
            decided_q     <= {SNAP_W{1'b0}};
            ninety_q      <= 1'b0;
        end else if (!enable) begin
            state_q       <= IDLE;
            dir_cmd       <= STOP;
            cmd_strobe    <= (dir_cmd != STOP);
            intersect_evt <= 1'b0;
            lost_line     <= 1'b0;
            deb_cnt_q     <= {DEB_W{1'b0}};
            srch_cnt_q    <= {SRCH_W{1'b0}};
            ninety_q      <= 1'b0;
        end else begin
            cmd_strobe    <= 1'b0;
            intersect_evt <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q   <= DEBOUNCE;
                    snap_q    <= snap_s;
                    deb_cnt_q <= {DEB_W{1'b0}};
                end
                TRACK: begin
                    if (snap_s != decided_q) begin
                        state_q   <= DEBOUNCE;
                        snap_q    <= snap_s;
                        deb_cnt_q <= {DEB_W{1'b0}};
                    end else begin
                        state_q <= TRACK;
                    end
                end
                DEBOUNCE: begin
                    if (snap_s != snap_q) begin
                        snap_q    <= snap_s;
                        deb_cnt_q <= {DEB_W{1'b0}};
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= DECIDE;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                    end
                end
                DECIDE: begin
                    decided_q <= snap_q;
                    if (dec_bar_s != {N_SENS{1'b0}}) begin
                        dir_cmd    <= grade_s;
                        cmd_strobe <= (grade_s != dir_cmd);
                        lost_line  <= 1'b0;
                        state_q    <= TRACK;
                    end else begin
                        srch_cnt_q <= {SRCH_W{1'b0}};
                        ninety_q   <= 1'b0;
                        state_q    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (srch_cnt_q == SRCH_LAST) begin
                        dir_cmd    <= STOP;
                        cmd_strobe <= (dir_cmd != STOP);
                        lost_line  <= 1'b1;
                        decided_q  <= snap_s;
                        state_q    <= TRACK;
                    end else if (mid_s == 2'b11) begin
                        dir_cmd       <= STOP;
                        cmd_strobe    <= (dir_cmd != STOP);
                        intersect_evt <= 1'b1;
                        decided_q     <= snap_s;
                        state_q       <= TRACK;
                    end else begin
                        // Once a turn is signalled, keep turning even after the middle pair clears.
                        if (mid_s == 2'b01) begin
                            dir_cmd    <= NINETY_LEFT;
                            cmd_strobe <= (dir_cmd != NINETY_LEFT);
                            ninety_q   <= 1'b1;
                        end else if (mid_s == 2'b10) begin
                            dir_cmd    <= NINETY_RIGHT;
                            cmd_strobe <= (dir_cmd != NINETY_RIGHT);
                            ninety_q   <= 1'b1;
                        end else if (!ninety_q) begin
                            dir_cmd    <= PROCEED;
                            cmd_strobe <= (dir_cmd != PROCEED);
                            srch_cnt_q <= srch_cnt_q + SRCH_W'(1);
                        end else begin
                            dir_cmd <= dir_cmd;
                        end
                        if (bar_s != {N_SENS{1'b0}}) begin
                            state_q   <= DEBOUNCE;
                            snap_q    <= snap_s;
                            deb_cnt_q <= {DEB_W{1'b0}};
                            lost_line <= 1'b0;
                            ninety_q  <= 1'b0;
                        end else begin
                            state_q <= SEARCH;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    dir_cmd    <= STOP;
                    cmd_strobe <= (dir_cmd != STOP);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Scoreboard bench for line_steer_ctrl: stimulus pushes expected command events, a monitor checks them.
module tb_line_steer_ctrl;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int DC  = 8;
    localparam int IC  = 50;
    localparam int VT  = 1;
    localparam int LAT = SS + DC + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         direction;
    logic [N-1:0] front_n;
    logic [N-1:0] rear_n;
    logic [1:0]   mid_n;
    logic [3:0]   dir_cmd;
    logic         cmd_strobe;
    logic         intersect_evt;
    logic         lost_line;

    typedef struct {
        logic [3:0] cmd;
        logic       evt;
        logic       lost;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cur  = 4'b1111;
    logic       exp_lost = 1'b0;
    logic [3:0] mdl_cmd    = 4'b1111;
    logic       mdl_lost   = 1'b0;
    logic       mdl_search = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    line_steer_ctrl #(
        .N_SENS        (N),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_CYC  (DC),
        .INTERSECT_CYC (IC),
        .VEER_THRESH   (VT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .direction     (direction),
        .sens_front_n  (front_n),
        .sens_rear_n   (rear_n),
        .sens_mid_n    (mid_n),
        .dir_cmd       (dir_cmd),
        .cmd_strobe    (cmd_strobe),
        .intersect_evt (intersect_evt),
        .lost_line     (lost_line)
    );

    // Reference grading from sensor counts on each half of the bar (bar here is 1 = line seen).
    function automatic logic [3:0] grade(input logic [N-1:0] bar);
        int l;
        int r;
        l = 0;
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (bar[i]) begin
                if (i >= N / 2) l++;
                else r++;
            end
        end
        if (l - r > VT) return 4'b0110;
        if (l > r) return 4'b0101;
        if (r - l > VT) return 4'b1010;
        if (r > l) return 4'b1001;
        return 4'b0000;
    endfunction

    task automatic push(input logic [3:0] c, input logic e, input logic l, input int at);
        sb.push_back('{c, e, l, at});
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Apply a pin pattern at a falling edge and predict the resulting command events.
    task automatic step(input logic d, input logic [N-1:0] f, input logic [N-1:0] r,
                        input logic [1:0] m, input int hold);
        logic [N-1:0] bar;
        logic [1:0]   mid;
        logic [3:0]   g;
        int           t0;
        @(negedge clk);
        direction = d;
        front_n   = f;
        rear_n    = r;
        mid_n     = m;
        t0        = cyc;
        bar       = d ? ~f : ~r;
        mid       = ~m;
        if (mdl_search) begin
            if (mid == 2'b11) begin
                push(4'b1111, 1'b1, mdl_lost, t0 + SS + 1);
                mdl_cmd    = 4'b1111;
                mdl_search = 1'b0;
            end
        end else if (bar != '0) begin
            g = grade(bar);
            if (g != mdl_cmd) push(g, 1'b0, 1'b0, t0 + LAT);
            mdl_cmd  = g;
            mdl_lost = 1'b0;
        end else if (mid == 2'b00) begin
            if (mdl_cmd != 4'b0000) push(4'b0000, 1'b0, mdl_lost, t0 + LAT + 1);
            push(4'b1111, 1'b0, 1'b1, t0 + LAT + IC);
            mdl_cmd  = 4'b1111;
            mdl_lost = 1'b1;
        end else if (mid == 2'b01) begin
            push(4'b0111, 1'b0, mdl_lost, t0 + LAT + 1);
            mdl_cmd    = 4'b0111;
            mdl_search = 1'b1;
        end else if (mid == 2'b10) begin
            push(4'b1011, 1'b0, mdl_lost, t0 + LAT + 1);
            mdl_cmd    = 4'b1011;
            mdl_search = 1'b1;
        end else begin
            push(4'b1111, 1'b1, mdl_lost, t0 + LAT + 1);
            mdl_cmd = 4'b1111;
        end
        repeat (hold) @(negedge clk);
    endtask

    // Monitor: pop an expectation on every strobe/event, otherwise the outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd_strobe || intersect_evt) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got cmd=%b strobe=%b evt=%b at cycle %0d, required no event",
                                 dir_cmd, cmd_strobe, intersect_evt, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (dir_cmd !== e.cmd || intersect_evt !== e.evt || lost_line !== e.lost ||
                            cmd_strobe !== (e.cmd != exp_cur) || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL event: got cmd=%b strobe=%b evt=%b lost=%b cyc=%0d, required cmd=%b strobe=%b evt=%b lost=%b cyc=%0d",
                                     dir_cmd, cmd_strobe, intersect_evt, lost_line, cyc,
                                     e.cmd, (e.cmd != exp_cur), e.evt, e.lost, e.cyc);
                        end
                        exp_cur  = e.cmd;
                        exp_lost = e.lost;
                    end
                end else begin
                    checks++;
                    if (dir_cmd !== exp_cur || lost_line !== exp_lost) begin
                        errors++;
                        $display("FAIL hold: got cmd=%b lost=%b at cycle %0d, required cmd=%b lost=%b",
                                 dir_cmd, lost_line, cyc, exp_cur, exp_lost);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d expected events pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] f;
        logic [N-1:0] r;
        rst_n     = 1'b0;
        enable    = 1'b0;
        direction = 1'b1;
        front_n   = 4'b1111;
        rear_n    = 4'b1111;
        mid_n     = 2'b11;
        repeat (3) @(negedge clk);
        chk("reset_dir_cmd", int'(dir_cmd), 15);
        chk("reset_strobe", int'(cmd_strobe), 0);
        chk("reset_intersect", int'(intersect_evt), 0);
        chk("reset_lost", int'(lost_line), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Enable together with a centred line.
        @(negedge clk);
        enable  = 1'b1;
        front_n = 4'b1001;
        push(4'b0000, 1'b0, 1'b0, cyc + LAT);
        mdl_cmd = 4'b0000;
        repeat (20) @(negedge clk);

        // Graded steering.
        step(1'b1, 4'b0111, 4'b1110, 2'b11, 20);
        step(1'b1, 4'b0011, 4'b1110, 2'b11, 20);
        step(1'b1, 4'b1100, 4'b1110, 2'b11, 20);
        step(1'b1, 4'b1001, 4'b1110, 2'b11, 20);

        // Short glitch must not change the command.
        @(negedge clk);
        front_n = 4'b0111;
        repeat (3) @(negedge clk);
        front_n = 4'b1001;
        repeat (20) @(negedge clk);

        // Ninety-degree turns and intersections.
        step(1'b1, 4'b1111, 4'b1110, 2'b10, 20);
        step(1'b1, 4'b1111, 4'b1110, 2'b00, 20);
        step(1'b1, 4'b1001, 4'b1110, 2'b11, 20);
        step(1'b1, 4'b1111, 4'b1110, 2'b01, 20);
        step(1'b1, 4'b1111, 4'b1110, 2'b00, 20);
        step(1'b1, 4'b1001, 4'b1110, 2'b11, 20);

        // Line lost until the search times out, then reacquired.
        step(1'b1, 4'b1111, 4'b1110, 2'b11, LAT + IC + 10);
        step(1'b1, 4'b1001, 4'b1110, 2'b11, 20);

        // Randomised bars and direction, always with some line on both bars.
        for (int i = 0; i < 20; i++) begin
            f = 4'($urandom_range(0, 14));
            r = 4'($urandom_range(0, 14));
            step(1'($urandom_range(0, 1)), f, r, 2'($urandom_range(0, 3)), LAT + 4);
        end

        // Direction toggle during debounce: the rear bar decides.
        step(1'b1, 4'b1001, 4'b1110, 2'b11, 20);
        @(negedge clk);
        front_n = 4'b1100;
        repeat (3) @(negedge clk);
        step(1'b0, 4'b1100, 4'b1110, 2'b11, 20);

        // Enable low forces STOP on the next edge; re-enable re-decides the stable bar.
        @(negedge clk);
        enable = 1'b0;
        push(4'b1111, 1'b0, 1'b0, cyc + 1);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        push(4'b1001, 1'b0, 1'b0, cyc + DC + 2);
        mdl_cmd = 4'b1001;
        repeat (16) @(negedge clk);

        // Reset asserted in the middle of a debounce.
        @(negedge clk);
        rear_n = 4'b0111;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_dir_cmd", int'(dir_cmd), 15);
        chk("async_reset_strobe", int'(cmd_strobe), 0);
        chk("async_reset_lost", int'(lost_line), 0);
        exp_cur  = 4'b1111;
        exp_lost = 1'b0;
        enable   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        chk("pending_events", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
